// File: rtl/sata_scrambler_mw_if.sv
// Stream bundle for the SATA scrambler: upstream beat in, downstream beat out.
// The master modport is the environment's view and the slave modport is the scrambler's view.
interface sata_scrambler_mw_if #(
    parameter int LANES = 1
);
    localparam int DW = 32 * LANES;

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sof;
    logic          in_eof;
    logic          in_bypass;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_sof;
    logic          out_eof;
    logic          out_oversize;

    modport master (
        output in_valid, in_data, in_sof, in_eof, in_bypass, out_ready,
        input  in_ready, out_valid, out_data, out_sof, out_eof, out_oversize
    );

    modport slave (
        input  in_valid, in_data, in_sof, in_eof, in_bypass, out_ready,
        output in_ready, out_valid, out_data, out_sof, out_eof, out_oversize
    );
endinterface

// File: rtl/sata_scrambler_mw.sv
// Multi-lane SATA scrambler/descrambler (x^16+x^15+x^13+x^4+1, Galois form).
// It uses a single stalling output register and counts dwords per frame to flag oversize frames.
module sata_scrambler_mw #(
    parameter int          LANES      = 1,
    parameter logic [15:0] SEED       = 16'hFFFF,
    parameter int          MAX_DWORDS = 2064
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    sata_scrambler_mw_if.slave bus,
    output logic [15:0]        lfsr_state
);
    localparam int          DW      = 32 * LANES;
    localparam logic [12:0] LANES_W = 13'(LANES);
    localparam logic [12:0] MAX_W   = 13'(MAX_DWORDS);

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], 1'b0} ^ (s[15] ? 16'hA011 : 16'h0000);
    endfunction

    logic [15:0]   lfsr;
    logic [11:0]   cnt;
    logic          accept;
    logic          scramble;
    logic [15:0]   s0;
    logic [15:0]   s_next;
    logic [DW-1:0] mask;
    logic [12:0]   cnt_sum;
    logic [11:0]   cnt_new;
    logic          over;

    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign accept       = bus.in_valid & bus.in_ready;
    assign scramble     = en & ~bus.in_bypass;
    assign s0           = bus.in_sof ? SEED : lfsr;
    assign lfsr_state   = lfsr;

    // One continuous bit stream across all lanes: lane k starts 32*k steps after S0.
    always_comb begin
        logic [15:0] s;
        s    = s0;
        mask = '0;
        for (int i = 0; i < DW; i++) begin
            mask[i] = s[15];
            s       = lfsr_step(s);
        end
        s_next = s;
    end

    assign cnt_sum = (bus.in_sof ? 13'd0 : {1'b0, cnt}) + LANES_W;
    assign cnt_new = cnt_sum[12] ? 12'hFFF : cnt_sum[11:0];
    assign over    = {1'b0, cnt_new} > MAX_W;

    // The output register doubles as the per-frame sticky oversize state, since it only loads on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr             <= SEED;
            cnt              <= '0;
            bus.out_valid    <= 1'b0;
            bus.out_data     <= '0;
            bus.out_sof      <= 1'b0;
            bus.out_eof      <= 1'b0;
            bus.out_oversize <= 1'b0;
        end else if (accept) begin
            bus.out_valid    <= 1'b1;
            bus.out_data     <= scramble ? (bus.in_data ^ mask) : bus.in_data;
            bus.out_sof      <= bus.in_sof;
            bus.out_eof      <= bus.in_eof;
            bus.out_oversize <= (bus.out_oversize & ~bus.in_sof) | over;
            cnt              <= cnt_new;
            if (scramble) begin
                lfsr <= s_next;
            end else if (bus.in_sof) begin
                lfsr <= SEED;
            end
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sata_scrambler_mw.sv
// Directed and randomised checks of sata_scrambler_mw at 1, 2 and 4 lanes.
// It includes a descrambler round trip, a bypass and enable model, backpressure stability, oversize handling and mid-frame reset.
`timescale 1ns/1ps
module tb_sata_scrambler_mw;
    localparam int NSTALL = 10000;

    logic clk = 1'b0;
    logic rst;
    logic en;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    sata_scrambler_mw_if #(.LANES(1)) b1  ();
    sata_scrambler_mw_if #(.LANES(2)) b2a ();
    sata_scrambler_mw_if #(.LANES(2)) b2b ();
    sata_scrambler_mw_if #(.LANES(4)) b4  ();
    logic [15:0] lfsr1, lfsr2a, lfsr2b, lfsr4;

    sata_scrambler_mw #(.LANES(1)) u1 (.clk(clk), .rst(rst), .en(en), .bus(b1), .lfsr_state(lfsr1));
    sata_scrambler_mw #(.LANES(2)) u2a (.clk(clk), .rst(rst), .en(en), .bus(b2a), .lfsr_state(lfsr2a));
    sata_scrambler_mw #(.LANES(2)) u2b (.clk(clk), .rst(rst), .en(en), .bus(b2b), .lfsr_state(lfsr2b));
    sata_scrambler_mw #(.LANES(4), .MAX_DWORDS(16)) u4 (.clk(clk), .rst(rst), .en(en), .bus(b4), .lfsr_state(lfsr4));

    // The second 2-lane instance descrambles the first one's output.
    assign b2b.in_valid  = b2a.out_valid;
    assign b2b.in_data   = b2a.out_data;
    assign b2b.in_sof    = b2a.out_sof;
    assign b2b.in_eof    = b2a.out_eof;
    assign b2b.in_bypass = 1'b0;
    assign b2a.out_ready = b2b.in_ready;

    // Reference bit-serial LFSR with the taps written out bit by bit.
    task automatic m_dword(inout logic [15:0] s, output logic [31:0] m);
        logic fb;
        for (int i = 0; i < 32; i++) begin
            fb   = s[15];
            m[i] = fb;
            s    = {s[14] ^ fb, s[13], s[12] ^ fb, s[11:4], s[3] ^ fb, s[2:0], fb};
        end
    endtask

    task automatic beat1(input logic [31:0] d, input logic sof, input logic eof, input logic byp);
        b1.in_data   = d;
        b1.in_sof    = sof;
        b1.in_eof    = eof;
        b1.in_bypass = byp;
        b1.in_valid  = 1'b1;
        @(negedge clk);
        b1.in_valid  = 1'b0;
    endtask

    task automatic beat4(input logic [127:0] d, input logic sof);
        b4.in_data   = d;
        b4.in_sof    = sof;
        b4.in_eof    = 1'b0;
        b4.in_bypass = 1'b0;
        b4.in_valid  = 1'b1;
        @(negedge clk);
        b4.in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b want 0", b1.out_valid); end
        n_cmp++; if (b1.out_data !== 32'h0) begin n_err++; $display("[TB] FAIL reset_data: got %h want 0", b1.out_data); end
        n_cmp++; if ({b1.out_sof, b1.out_eof, b1.out_oversize} !== 3'b000) begin n_err++; $display("[TB] FAIL reset_flags: got %b want 000", {b1.out_sof, b1.out_eof, b1.out_oversize}); end
        n_cmp++; if (lfsr1 !== 16'hFFFF) begin n_err++; $display("[TB] FAIL reset_lfsr: got %h want ffff", lfsr1); end
        n_cmp++; if (b4.out_oversize !== 1'b0) begin n_err++; $display("[TB] FAIL reset_ov4: got %b want 0", b4.out_oversize); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (b1.in_ready !== 1'b1) begin n_err++; $display("[TB] FAIL reset_ready: got %b want 1", b1.in_ready); end
    endtask

    task automatic test_lane1_vectors();
        logic [15:0] ms;
        logic [31:0] mk;
        ms = 16'hFFFF;
        beat1(32'h0, 1'b1, 1'b0, 1'b0);
        m_dword(ms, mk);
        n_cmp++; if (b1.out_data !== 32'hC2D2768D) begin n_err++; $display("[TB] FAIL l1_dw0: got %h want c2d2768d", b1.out_data); end
        n_cmp++; if ({b1.out_valid, b1.out_sof} !== 2'b11) begin n_err++; $display("[TB] FAIL l1_vs0: got %b want 11", {b1.out_valid, b1.out_sof}); end
        n_cmp++; if (lfsr1 !== ms) begin n_err++; $display("[TB] FAIL l1_lfsr0: got %h want %h", lfsr1, ms); end
        beat1(32'h0, 1'b0, 1'b1, 1'b0);
        m_dword(ms, mk);
        n_cmp++; if (b1.out_data !== 32'h1F26B368) begin n_err++; $display("[TB] FAIL l1_dw1: got %h want 1f26b368", b1.out_data); end
        n_cmp++; if ({b1.out_sof, b1.out_eof} !== 2'b01) begin n_err++; $display("[TB] FAIL l1_se1: got %b want 01", {b1.out_sof, b1.out_eof}); end
        n_cmp++; if (lfsr1 !== ms) begin n_err++; $display("[TB] FAIL l1_lfsr1: got %h want %h", lfsr1, ms); end
        @(negedge clk);
        n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL l1_drain: got %b want 0", b1.out_valid); end
    endtask

    task automatic test_lanes2_roundtrip();
        logic [63:0] q[$];
        logic [63:0] d;
        logic [63:0] exp;
        int got = 0;
        for (int cyc = 0; cyc < 520; cyc++) begin
            if (b2b.out_valid) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++; $display("[TB] FAIL rt_extra: got %h want none", b2b.out_data);
                end else begin
                    exp = q.pop_front();
                    n_cmp++; if (b2b.out_data !== exp) begin n_err++; $display("[TB] FAIL rt_data: got %h want %h", b2b.out_data, exp); end
                end
                got++;
            end
            if (cyc == 1) begin
                n_cmp++; if (b2a.out_data !== 64'h1F26B368_C2D2768D) begin n_err++; $display("[TB] FAIL l2_sof: got %h want 1f26b368c2d2768d", b2a.out_data); end
            end
            if (cyc < 500) begin
                d = (cyc == 0) ? 64'h0 : {$urandom, $urandom};
                b2a.in_data   = d;
                b2a.in_sof    = (cyc == 0) || ($urandom_range(0, 19) == 0);
                b2a.in_eof    = ($urandom_range(0, 19) == 0);
                b2a.in_bypass = 1'b0;
                b2a.in_valid  = 1'b1;
                q.push_back(d);
            end else begin
                b2a.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++; if (got !== 500) begin n_err++; $display("[TB] FAIL rt_count: got %0d want 500", got); end
        n_cmp++; if (lfsr2b !== lfsr2a) begin n_err++; $display("[TB] FAIL rt_lfsr: got %h want %h", lfsr2b, lfsr2a); end
    endtask

    task automatic test_bypass_enable();
        logic [15:0] ms;
        logic [31:0] mk, d, exp;
        logic sof, byp, ena;
        ms = 16'hFFFF;
        for (int i = 0; i < 48; i++) begin
            sof = (i == 0) || (i == 30);
            byp = (i > 0) && ($urandom_range(0, 2) == 0);
            ena = !(i == 10 || i == 11 || i == 25 || i == 30);
            d   = $urandom;
            en  = ena;
            beat1(d, sof, 1'b0, byp);
            if (sof) ms = 16'hFFFF;
            if (ena && !byp) begin
                m_dword(ms, mk);
                exp = d ^ mk;
            end else begin
                exp = d;
            end
            n_cmp++; if (b1.out_data !== exp) begin n_err++; $display("[TB] FAIL byp_data[%0d]: got %h want %h", i, b1.out_data, exp); end
            n_cmp++; if (lfsr1 !== ms) begin n_err++; $display("[TB] FAIL byp_lfsr[%0d]: got %h want %h", i, lfsr1, ms); end
        end
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_stall();
        logic [31:0] q_data[$];
        logic        q_sof[$];
        logic [15:0] ms;
        logic [31:0] mk, cur_d, exp_d, snap_d;
        logic        cur_sof, cur_byp, exp_sof, pending, prev_stall, exp_ready;
        logic [2:0]  snap_f;
        int sent = 0, got = 0, cyc = 0;
        ms = 16'hFFFF; pending = 1'b0; prev_stall = 1'b0;
        snap_d = '0; snap_f = '0; cur_d = '0; cur_sof = 1'b0; cur_byp = 1'b0;
        while (got < NSTALL && cyc < 40000) begin
            if (prev_stall) begin
                n_cmp++; if ({b1.out_valid, b1.out_sof, b1.out_eof, b1.out_data} !== {snap_f, snap_d}) begin
                    n_err++; $display("[TB] FAIL stall_hold: got %b/%h want %b/%h", {b1.out_valid, b1.out_sof, b1.out_eof}, b1.out_data, snap_f, snap_d); end
            end
            b1.out_ready = ($urandom_range(0, 9) >= 3);
            if (!pending && sent < NSTALL) begin
                cur_d   = $urandom;
                cur_sof = (sent % 64) == 0;
                cur_byp = ($urandom_range(0, 4) == 0);
                b1.in_data = cur_d; b1.in_sof = cur_sof; b1.in_eof = 1'b0; b1.in_bypass = cur_byp;
                b1.in_valid = 1'b1;
                pending = 1'b1;
            end else if (!pending) begin
                b1.in_valid = 1'b0;
            end
            #1;
            exp_ready = ~(b1.out_valid & ~b1.out_ready);
            n_cmp++; if (b1.in_ready !== exp_ready) begin n_err++; $display("[TB] FAIL stall_ready: got %b want %b", b1.in_ready, exp_ready); end
            if (b1.out_valid && b1.out_ready) begin
                if (q_data.size() == 0) begin
                    n_cmp++; n_err++; $display("[TB] FAIL stall_dup: got %h want none", b1.out_data);
                end else begin
                    exp_d = q_data.pop_front();
                    exp_sof = q_sof.pop_front();
                    n_cmp++; if ({b1.out_sof, b1.out_data} !== {exp_sof, exp_d}) begin
                        n_err++; $display("[TB] FAIL stall_data: got %b/%h want %b/%h", b1.out_sof, b1.out_data, exp_sof, exp_d); end
                end
                got++;
            end
            if (pending && b1.in_ready) begin
                if (cur_sof) ms = 16'hFFFF;
                if (cur_byp) begin
                    exp_d = cur_d;
                end else begin
                    m_dword(ms, mk);
                    exp_d = cur_d ^ mk;
                end
                q_data.push_back(exp_d);
                q_sof.push_back(cur_sof);
                sent++;
                pending = 1'b0;
            end
            prev_stall = b1.out_valid && !b1.out_ready;
            snap_d = b1.out_data;
            snap_f = {b1.out_valid, b1.out_sof, b1.out_eof};
            @(negedge clk);
            cyc++;
        end
        b1.in_valid = 1'b0;
        b1.out_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (got !== NSTALL) begin n_err++; $display("[TB] FAIL stall_count: got %0d want %0d", got, NSTALL); end
        n_cmp++; if (q_data.size() !== 0) begin n_err++; $display("[TB] FAIL stall_left: got %0d want 0", q_data.size()); end
    endtask

    task automatic test_oversize();
        logic [15:0] ms;
        logic [31:0] mk;
        ms = 16'hFFFF;
        for (int k = 0; k < 4; k++) m_dword(ms, mk);
        beat4(128'h0, 1'b1);
        n_cmp++; if (b4.out_data[63:0] !== 64'h1F26B368_C2D2768D) begin n_err++; $display("[TB] FAIL l4_sof: got %h want 1f26b368c2d2768d", b4.out_data[63:0]); end
        n_cmp++; if (lfsr4 !== ms) begin n_err++; $display("[TB] FAIL l4_lfsr: got %h want %h", lfsr4, ms); end
        n_cmp++; if (b4.out_oversize !== 1'b0) begin n_err++; $display("[TB] FAIL ov_beat1: got %b want 0", b4.out_oversize); end
        for (int j = 2; j <= 6; j++) begin
            beat4({$urandom, $urandom, $urandom, $urandom}, 1'b0);
            n_cmp++; if (b4.out_oversize !== (j >= 5)) begin n_err++; $display("[TB] FAIL ov_beat%0d: got %b want %b", j, b4.out_oversize, (j >= 5)); end
        end
        beat4(128'h0, 1'b1);
        n_cmp++; if (b4.out_oversize !== 1'b0) begin n_err++; $display("[TB] FAIL ov_clear: got %b want 0", b4.out_oversize); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        b1.out_ready = 1'b0;
        beat1(32'h1234_5678, 1'b1, 1'b0, 1'b0);
        beat1(32'h0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (b1.out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL mid_held: got %b want 1", b1.out_valid); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (b1.out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL mid_drop: got %b want 0", b1.out_valid); end
        n_cmp++; if (lfsr1 !== 16'hFFFF) begin n_err++; $display("[TB] FAIL mid_lfsr: got %h want ffff", lfsr1); end
        @(negedge clk);
        rst = 1'b0;
        b1.out_ready = 1'b1;
        beat1(32'h0, 1'b0, 1'b0, 1'b0);
        n_cmp++; if (b1.out_data !== 32'hC2D2768D) begin n_err++; $display("[TB] FAIL mid_seed: got %h want c2d2768d", b1.out_data); end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        b1.in_valid = 1'b0; b1.in_data = '0; b1.in_sof = 1'b0; b1.in_eof = 1'b0; b1.in_bypass = 1'b0; b1.out_ready = 1'b1;
        b2a.in_valid = 1'b0; b2a.in_data = '0; b2a.in_sof = 1'b0; b2a.in_eof = 1'b0; b2a.in_bypass = 1'b0;
        b2b.out_ready = 1'b1;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_sof = 1'b0; b4.in_eof = 1'b0; b4.in_bypass = 1'b0; b4.out_ready = 1'b1;
        test_reset();
        test_lane1_vectors();
        test_lanes2_roundtrip();
        test_bypass_enable();
        test_stall();
        test_oversize();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
